// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Purpose : Types and default sizing shared by the UART receive-side blocks.
// Contents: byte_t                   - one UART character
//           UART_DEFAULT_FIFO_DEPTH  - default receive FIFO depth
//           UART_DEFAULT_HEADROOM    - default free-entry threshold for RTS
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef logic [7:0] byte_t;

   localparam int unsigned UART_DEFAULT_FIFO_DEPTH = 16;
   localparam int unsigned UART_DEFAULT_HEADROOM   = 4;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// Purpose : Byte path into and out of the receive FIFO.
// Signals : in_data   - received byte from the UART receiver
//           in_valid  - one-cycle strobe qualifying in_data
//           out_data  - head-of-FIFO byte
//           out_valid - FIFO not empty
//           out_ready - consumer accepts the head byte this cycle
// Modports: master - receiver/consumer side (drives in_*, out_ready)
//           slave  - FIFO side (drives out_data, out_valid)
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if;
   import uart_pkg::*;

   byte_t in_data;
   logic  in_valid;
   byte_t out_data;
   logic  out_valid;
   logic  out_ready;

   modport master (
      output in_data,
      output in_valid,
      output out_ready,
      input  out_data,
      input  out_valid
   );

   modport slave (
      input  in_data,
      input  in_valid,
      input  out_ready,
      output out_data,
      output out_valid
   );

endinterface : uart_rx_fifo_if

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
// Purpose : DEPTH x 8 byte storage, synchronous write, asynchronous read.
//           Contents are not reset.
// Ports   : clk      - clock
//           i_we     - write enable
//           i_waddr  - write address
//           i_wdata  - write data
//           i_raddr  - read address
//           o_rdata  - read data (combinational from i_raddr)
// -----------------------------------------------------------------------------
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = UART_DEFAULT_FIFO_DEPTH,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  byte_t         i_wdata,
   input  logic [AW-1:0] i_raddr,
   output byte_t         o_rdata
);

   byte_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Purpose : First-word-fall-through receive FIFO behind the UART receiver,
//           with registered RTS flow control and a sticky overrun flag.
// Ports   : clk         - clock
//           reset       - synchronous, active-high reset
//           bus         - byte path (slave modport: in_data/in_valid,
//                         out_data/out_valid/out_ready)
//           rts         - 1 while free entries >= HEADROOM (registered)
//           level       - occupancy, 0..DEPTH
//           overrun     - sticky, set when a byte arrives while full
//           overrun_clr - clears overrun (and overrun_cnt)
//           overrun_cnt - dropped-byte count, saturating at 255; present only
//                         when UART_RX_FIFO_OVERRUN_CNT_EN is defined
// Build   : UART_RX_FIFO_OVERRUN_CNT_EN enables the overrun counter.
// -----------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH    = UART_DEFAULT_FIFO_DEPTH,
   parameter int unsigned HEADROOM = UART_DEFAULT_HEADROOM,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   uart_rx_fifo_if.slave      bus,
   output logic               rts,
   output logic [AW:0]        level,
   output logic               overrun,
`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
   output logic [7:0]         overrun_cnt,
`endif
   input  logic               overrun_clr
);

   localparam logic [AW:0] LP_DEPTH    = (AW+1)'(DEPTH);
   localparam logic [AW:0] LP_HEADROOM = (AW+1)'(HEADROOM);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        r_rts;
   logic        r_overrun;

   logic [AW:0] w_level;
   logic [AW:0] w_free;
   logic        w_empty;
   logic        w_full;
   logic        w_push;
   logic        w_pop;
   logic        w_drop;
   byte_t       w_rdata;

   // Pointers carry one extra wrap bit so full and empty stay distinct.
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_free  = LP_DEPTH - w_level;
   assign w_empty = (w_level == '0);
   assign w_full  = (w_level == LP_DEPTH);

   // Full is judged on the pre-edge level: a byte arriving at a full FIFO is
   // dropped even if the head is popped in the same cycle.
   assign w_push = bus.in_valid && !w_full;
   assign w_drop = bus.in_valid &&  w_full;
   assign w_pop  = bus.out_ready && !w_empty;

   uart_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (bus.in_data),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // RTS is registered from the current level, so it trails level by a cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rts <= 1'b1;
      end else begin
         r_rts <= (w_free >= LP_HEADROOM);
      end
   end

   // A drop outranks a clear arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (overrun_clr) begin
         r_overrun <= 1'b0;
      end
   end

`ifdef UART_RX_FIFO_OVERRUN_CNT_EN
   logic [7:0] r_overrun_cnt;

   // Clear restarts the count, so a clear with a drop leaves exactly one.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overrun_cnt <= '0;
      end else if (overrun_clr) begin
         r_overrun_cnt <= w_drop ? 8'd1 : 8'd0;
      end else if (w_drop && (r_overrun_cnt != '1)) begin
         r_overrun_cnt <= r_overrun_cnt + 8'd1;
      end
   end

   assign overrun_cnt = r_overrun_cnt;
`endif

   assign bus.out_valid = !w_empty;
   assign bus.out_data  = w_rdata;
   assign level         = w_level;
   assign rts           = r_rts;
   assign overrun       = r_overrun;

endmodule : uart_rx_fifo
